// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helpers for the asynchronous FIFO pointer blocks.
// Helpers work on a wide zero-extended vector so any pointer width up to MAX_W can use them.
package fifo_pkg;

    localparam int unsigned DEF_ADDR_SIZE = 4;
    localparam int unsigned DEF_PTR_W     = DEF_ADDR_SIZE + 1;
    localparam int unsigned MAX_W         = 32;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray);
        logic [MAX_W-1:0] bin;
        bin[MAX_W-1] = gray[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module fifo_gray2bin #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full flag, fill level, almost-full and sticky overflow for the async FIFO.
// Level and full use the synchronised read pointer, so they are stale-pessimistic by design.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned AF_MARGIN = 2
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 woverflow
);

    localparam int unsigned DEPTH = 1 << ADDR_SIZE;
    localparam int unsigned PTR_W = ADDR_SIZE + 1;
    localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(DEPTH - AF_MARGIN);

    logic [PTR_W-1:0] wbin_q, wbin_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] wlevel_q, wlevel_d;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] full_gray;
    logic             wfull_q, wfull_d;
    logic             walmost_full_q, walmost_full_d;
    logic             woverflow_q, woverflow_d;
    logic             wpush;

    fifo_gray2bin #(
        .WIDTH(PTR_W)
    ) u_rptr_gray2bin (
        .gray(wq2_rptr),
        .bin (rbin)
    );

    always_comb begin
        wpush          = winc && !wfull_q;
        wbin_d         = wbin_q + {{ADDR_SIZE{1'b0}}, wpush};
        wptr_d         = PTR_W'(bin2gray(MAX_W'(wbin_d)));
        // Full when the write pointer is one lap ahead: top two Gray bits inverted.
        full_gray      = {~wq2_rptr[ADDR_SIZE -: 2], wq2_rptr[ADDR_SIZE-2:0]};
        wfull_d        = (wptr_d == full_gray);
        wlevel_d       = wbin_d - rbin;
        walmost_full_d = (wlevel_d >= AF_LEVEL);
        woverflow_d    = woverflow_q || (winc && wfull_q);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wlevel_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wlevel_q       <= wlevel_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign waddr        = wbin_q[ADDR_SIZE-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full with ADDR_SIZE=4, AF_MARGIN=2.
module tb_fifo_wptr_full;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       winc = 1'b0;
    logic [4:0] wq2_rptr = 5'd0;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;

    int total = 0;
    int bad   = 0;

    fifo_wptr_full #(
        .ADDR_SIZE(4),
        .AF_MARGIN(2)
    ) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .winc        (winc),
        .wq2_rptr    (wq2_rptr),
        .waddr       (waddr),
        .wptr        (wptr),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wlevel      (wlevel),
        .woverflow   (woverflow)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [4:0] gray(input int x);
        logic [4:0] b;
        b = 5'(x);
        return b ^ (b >> 1);
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ".waddr"}, 32'(waddr), 0);
        check({tag, ".wptr"}, 32'(wptr), 0);
        check({tag, ".wlevel"}, 32'(wlevel), 0);
        check({tag, ".wfull"}, 32'(wfull), 0);
        check({tag, ".walmost"}, 32'(walmost_full), 0);
        check({tag, ".wovf"}, 32'(woverflow), 0);
    endtask

    initial begin
        // Reset with winc held high: write must be dropped.
        wrst = 1'b1;
        winc = 1'b1;
        tick();
        tick();
        check_zero("reset");
        wrst = 1'b0;
        winc = 1'b0;
        tick();
        check_zero("idle");

        // Fill 16 entries against an empty read pointer.
        for (int i = 0; i < 16; i++) begin
            check("fill.waddr", 32'(waddr), 32'(i));
            winc = 1'b1;
            tick();
            check("fill.wlevel", 32'(wlevel), 32'(i + 1));
            check("fill.walmost", 32'(walmost_full), 32'((i + 1) >= 14));
            check("fill.wfull", 32'(wfull), 32'((i + 1) == 16));
        end
        check("fill.wptr", 32'(wptr), 32'h18);

        // Write while full is rejected and sets sticky overflow.
        winc = 1'b1;
        tick();
        check("ovf.wptr", 32'(wptr), 32'h18);
        check("ovf.waddr", 32'(waddr), 0);
        check("ovf.wlevel", 32'(wlevel), 16);
        check("ovf.flag", 32'(woverflow), 1);
        winc = 1'b0;
        tick();
        check("ovf.sticky", 32'(woverflow), 1);

        // Drain one, refill one, sixteen times: pointer wraps back to zero.
        for (int k = 1; k <= 16; k++) begin
            wq2_rptr = gray(k);
            winc = 1'b0;
            tick();
            check("wrap.nofull", 32'(wfull), 0);
            check("wrap.lvl15", 32'(wlevel), 15);
            check("wrap.waddr", 32'(waddr), 32'((k - 1) % 16));
            winc = 1'b1;
            tick();
            check("wrap.lvl16", 32'(wlevel), 16);
            check("wrap.full", 32'(wfull), 1);
        end
        winc = 1'b0;
        check("wrap.wptr", 32'(wptr), 0);
        check("wrap.waddr0", 32'(waddr), 0);
        check("wrap.ovf", 32'(woverflow), 1);

        // Reset, then fill to level 8 and do a simultaneous write + read advance.
        wrst = 1'b1;
        wq2_rptr = 5'd0;
        tick();
        check_zero("reset2");
        wrst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            winc = 1'b1;
            tick();
        end
        check("sim.pre", 32'(wlevel), 8);
        wq2_rptr = gray(1);
        winc = 1'b1;
        tick();
        check("sim.wlevel", 32'(wlevel), 8);
        check("sim.wfull", 32'(wfull), 0);
        check("sim.walmost", 32'(walmost_full), 0);
        check("sim.waddr", 32'(waddr), 9);
        check("sim.wptr", 32'(wptr), 32'(gray(9)));

        // Two more writes to level 10, then reset mid-fill.
        tick();
        tick();
        winc = 1'b0;
        check("mid.wlevel", 32'(wlevel), 10);
        wrst = 1'b1;
        winc = 1'b1;
        tick();
        check_zero("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_full.md
# fifo_wptr_full

Write-domain pointer and full-flag generator for the asynchronous FIFO. Runs entirely on the write clock, owns the binary/Gray write pointer, and drives the write address and full indication into the FIFO memory. Also publishes the Gray write pointer toward the read-domain synchroniser, plus fill level, almost-full and sticky overflow status for the producer.

## Interface
Parameters:
- ADDR_SIZE, 4, memory address width; DEPTH = 1<<ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
- AF_MARGIN, 2, almost-full threshold: asserted when level >= DEPTH-AF_MARGIN; legal range 1..DEPTH-1.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- wclk  input  1  write clock; all state updates on its rising edge.
- wrst  input  1  reset, synchronous to wclk, active-high.
- winc  input  1  write request from producer.
- wq2_rptr  input  ADDR_SIZE+1  Gray read pointer, already two-flop synchronised into wclk.
- waddr  output  ADDR_SIZE  write address to FIFO memory (binary pointer LSBs).
- wptr  output  ADDR_SIZE+1  registered Gray write pointer, to read-domain synchroniser.
- wfull  output  1  FIFO full, registered.
- walmost_full  output  1  level >= DEPTH-AF_MARGIN, registered.
- wlevel  output  ADDR_SIZE+1  entries held, as seen from write side (0..DEPTH), registered.
- woverflow  output  1  sticky: a write was attempted while full.

## Operation
- Write accepted (wpush) = winc && !wfull. Memory applies the same qualification; this block must not advance on a rejected write.
- wbin_next = wbin + wpush (ADDR_SIZE+1 bits, wraps modulo 2*DEPTH); wgray_next = wbin_next ^ (wbin_next >> 1).
- Full: wfull_next = (wgray_next == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]}).
- Level: rbin = Gray-to-binary of wq2_rptr; wlevel_next = (wbin_next - rbin) modulo 2*DEPTH. Never exceeds DEPTH for a legal read pointer.
- walmost_full_next = (wlevel_next >= DEPTH-AF_MARGIN).
- woverflow set when winc && wfull; cleared only by wrst.
- Read progress is seen only via wq2_rptr; full/level are pessimistic (stale by sync latency), never optimistic.
- Reset: wbin, wptr, waddr, wlevel = 0; wfull, walmost_full, woverflow = 0. Reset has priority over a simultaneous winc; the write is dropped and not counted.
- No FSM beyond the pointer register; reset mid-fill discards all pointer state (the read side must be reset together).

## Timing
- All outputs registered; one-cycle update after the wclk edge on which winc is sampled.
- waddr for a write is the value held during the cycle winc is high; it advances on that edge.
- wfull asserts on the same edge as the write that fills the last slot; the next winc is rejected.
- wfull deasserts the cycle after wq2_rptr changes to show free space (sync latency belongs to the synchroniser, not this block).
- Simultaneous write and read-pointer advance: both applied in wlevel_next in one cycle; level unchanged.
- Wrap: pointer rolls 2*DEPTH-1 -> 0; MSB toggle distinguishes full from empty.

## Structure
- Shared package fifo_pkg: default ADDR_SIZE, bin2gray and gray2bin functions, pointer-width constant (ADDR_SIZE+1). The same functions are reused by the read-pointer/empty block.
- One sub-module: fifo_gray2bin (parameterised width, combinational XOR prefix) converting wq2_rptr to rbin.

## Test plan
- Reset: assert wrst for 2 cycles with winc=1 -> all outputs 0, waddr=0, wptr=5'b00000.
- Fill (ADDR_SIZE=4, wq2_rptr=0): 16 consecutive winc -> waddr 0..15, wlevel 1..16; walmost_full rises after the 14th write; wfull rises after the 16th write with wptr=5'b11000.
- Overflow: while full, winc=1 for one cycle -> wptr/waddr unchanged, woverflow=1 and stays 1 until wrst.
- Drain and wrap: from full, step wq2_rptr through the Gray codes of 1..16 while writing 16 more -> waddr wraps 15->0, wptr returns to 5'b00000 after 32 writes, no false full.
- Simultaneous: level 8, winc=1 on the same edge wq2_rptr advances by one -> wlevel stays 8, wfull=0.
- Reset mid-fill: at level 10 assert wrst -> next cycle wlevel=0, wfull=0, walmost_full=0, waddr=0.
